// File: rtl/hdmi_pixel_stream_if.sv
// Capture-side pixel write bus for hdmi_pixel_stream.
//   wr_valid  capture pixel valid
//   wr_ready  sink can accept (FIFO not full)
//   wr_data   {r,g,b} pixel, 3*B bits
//   wr_sof    wr_data is pixel (0,0) of a frame
// master = capture side, slave = hdmi_pixel_stream.
interface hdmi_pixel_stream_if #(
  parameter int B = 8
);
  logic           wr_valid;
  logic           wr_ready;
  logic [3*B-1:0] wr_data;
  logic           wr_sof;

  modport master (output wr_valid, output wr_data, output wr_sof, input wr_ready);
  modport slave  (input wr_valid, input wr_data, input wr_sof, output wr_ready);
endinterface

// File: rtl/hdmi_pixel_stream.sv
// Pixel source for the HDMI-TX path. Buffers captured RGB pixels (tagged with a
// start-of-frame marker) in a FIFO and pops one per active pixel of the sync_vg
// timing, keeping output frames aligned to the captured frame boundaries.
// Ports:
//   clk, reset           pixel clock; asynchronous active-low reset
//   wr                   capture write bus (slave modport)
//   vn_in/hn_in/dn_in    sync_vg timing in
//   vn_out/hn_out/den_out timing delayed 1 clk
//   r_out/g_out/b_out    pixel aligned with den_out
//   fifo_level           entries held, 0..2**ADDR_BITS
//   synced               high while streaming
//   underflow, desync    sticky error flags, cleared by clr_flags
//
// state        | meaning
// S_RESYNC     | discard FIFO entries until the head carries an SOF marker
// S_WAIT_FRAME | head is an SOF pixel; hold it until the next frame start
// S_STREAM     | pop one entry per active pixel, checking frame alignment
module hdmi_pixel_stream #(
  parameter int             B           = 8,
  parameter int             ADDR_BITS   = 10,
  parameter logic           VS_ACTIVE   = 1'b1,
  parameter logic [3*B-1:0] DEFAULT_RGB = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  hdmi_pixel_stream_if.slave   wr,
  input  logic                 vn_in,
  input  logic                 hn_in,
  input  logic                 dn_in,
  output logic                 vn_out,
  output logic                 hn_out,
  output logic                 den_out,
  output logic [B-1:0]         r_out,
  output logic [B-1:0]         g_out,
  output logic [B-1:0]         b_out,
  output logic [ADDR_BITS:0]   fifo_level,
  output logic                 synced,
  output logic                 underflow,
  output logic                 desync,
  input  logic                 clr_flags
);
  localparam int                 W        = 3 * B;
  localparam int                 DEPTH    = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS:0] FULL_LVL = (ADDR_BITS + 1)'(DEPTH);

  typedef enum logic [1:0] {S_RESYNC, S_WAIT_FRAME, S_STREAM} state_t;

  logic [W:0]           r_mem [DEPTH];
  logic [ADDR_BITS-1:0] r_wr_ptr, r_rd_ptr;
  logic [ADDR_BITS:0]   r_level;
  state_t               r_state, w_next;
  logic                 r_first_pix, w_first_nxt, w_fp;
  logic                 r_vn_d, r_hn_d, r_den_d;
  logic [W-1:0]         r_rgb, w_rgb_nxt;
  logic                 r_underflow, r_desync;
  logic                 w_full, w_empty, w_wr, w_pop, w_set_uf, w_set_ds;
  logic                 w_frame_start, w_head_sof;
  logic [W-1:0]         w_head_rgb;

  // Ready is forced low while reset is held so nothing is accepted during reset.
  assign w_full        = (r_level == FULL_LVL);
  assign w_empty       = (r_level == '0);
  assign wr.wr_ready   = reset & ~w_full;
  assign w_wr          = wr.wr_valid & wr.wr_ready;
  assign w_head_sof    = r_mem[r_rd_ptr][W];
  assign w_head_rgb    = r_mem[r_rd_ptr][W-1:0];
  // r_vn_d doubles as vn_out, so the edge detect costs no extra flop.
  assign w_frame_start = (vn_in == VS_ACTIVE) && (r_vn_d != VS_ACTIVE);

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= {wr.wr_sof, wr.wr_data};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + ADDR_BITS'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + ADDR_BITS'(1);
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + (ADDR_BITS + 1)'(1);
        2'b01:   r_level <= r_level - (ADDR_BITS + 1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_RESYNC;
      r_first_pix <= 1'b0;
      r_vn_d      <= 1'b0;
      r_hn_d      <= 1'b0;
      r_den_d     <= 1'b0;
      r_rgb       <= '0;
      r_underflow <= 1'b0;
      r_desync    <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_first_pix <= w_first_nxt;
      r_vn_d      <= vn_in;
      r_hn_d      <= hn_in;
      r_den_d     <= dn_in;
      r_rgb       <= w_rgb_nxt;
      r_underflow <= w_set_uf | (r_underflow & ~clr_flags);
      r_desync    <= w_set_ds | (r_desync & ~clr_flags);
    end
  end

  always_comb begin
    w_next      = r_state;
    w_pop       = 1'b0;
    w_first_nxt = r_first_pix;
    w_fp        = r_first_pix;
    w_rgb_nxt   = dn_in ? DEFAULT_RGB : '0;
    w_set_uf    = 1'b0;
    w_set_ds    = 1'b0;
    case (r_state)
      S_RESYNC: begin
        if (!w_empty) begin
          if (w_head_sof) w_next = S_WAIT_FRAME;
          else            w_pop  = 1'b1;
        end
      end
      S_WAIT_FRAME: begin
        if (w_frame_start) begin
          w_next      = S_STREAM;
          w_first_nxt = 1'b1;
        end
      end
      S_STREAM: begin
        // frame start is applied before the active-pixel rules of the same cycle
        if (w_frame_start) w_fp = 1'b1;
        w_first_nxt = w_fp;
        if (dn_in) begin
          if (w_empty) begin
            w_set_uf = 1'b1;
          end else if (w_fp) begin
            if (w_head_sof) begin
              w_pop       = 1'b1;
              w_rgb_nxt   = w_head_rgb;
              w_first_nxt = 1'b0;
            end else begin
              w_set_ds = 1'b1;
              w_next   = S_RESYNC;
            end
          end else if (!w_head_sof) begin
            w_pop     = 1'b1;
            w_rgb_nxt = w_head_rgb;
          end else begin
            // next frame's SOF arrived early: keep it for the next frame start
            w_set_ds = 1'b1;
            w_next   = S_WAIT_FRAME;
          end
        end
      end
      default: w_next = S_RESYNC;
    endcase
  end

  assign vn_out     = r_vn_d;
  assign hn_out     = r_hn_d;
  assign den_out    = r_den_d;
  assign r_out      = r_rgb[W-1:2*B];
  assign g_out      = r_rgb[2*B-1:B];
  assign b_out      = r_rgb[B-1:0];
  assign fifo_level = r_level;
  assign synced     = (r_state == S_STREAM);
  assign underflow  = r_underflow;
  assign desync     = r_desync;
endmodule
